// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quad motor mixer: speed limits, state
// encodings, X-quad sign table and the widened signed sum type.
package quad_pkg;

    localparam int QUAD_MIN_SPEED = 256;
    localparam int QUAD_MAX_SPEED = 65535;

    localparam int ST_IDLE  = 0;
    localparam int ST_MIX   = 1;
    localparam int ST_CLAMP = 2;
    localparam int ST_ISSUE = 3;

    // 16-bit throttle plus three 16-bit signed terms needs 19 signed bits.
    typedef logic signed [18:0] sum19_t;

    // Per motor, bit 2/1/0 set means roll/pitch/yaw is subtracted.
    localparam logic [3:0][2:0] MIX_NEG = {3'b010, 3'b111, 3'b100, 3'b001};

    function automatic sum19_t mix_sum(input logic [15:0] t, input logic [15:0] r,
                                       input logic [15:0] p, input logic [15:0] y,
                                       input logic [2:0] neg);
        sum19_t acc;
        sum19_t rr;
        sum19_t pp;
        sum19_t yy;
        acc = sum19_t'({3'b000, t});
        rr  = {{3{r[15]}}, r};
        pp  = {{3{p[15]}}, p};
        yy  = {{3{y[15]}}, y};
        acc = neg[2] ? acc - rr : acc + rr;
        acc = neg[1] ? acc - pp : acc + pp;
        acc = neg[0] ? acc - yy : acc + yy;
        return acc;
    endfunction

endpackage

// File: rtl/motor_mix_dispatch_if.sv
// Command and PWM-channel bundle between the attitude controller side (master)
// and the mixer/dispatcher (slave).
interface motor_mix_dispatch_if;
    logic [15:0]        throttle;
    logic signed [15:0] roll;
    logic signed [15:0] pitch;
    logic signed [15:0] yaw;
    logic               arm;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [3:0]         pwm_busy;
    logic [63:0]        speed_out;
    logic [3:0]         speed_oe;
    logic               err;

    modport master (
        output throttle, roll, pitch, yaw, arm, cmd_valid, pwm_busy,
        input  cmd_ready, speed_out, speed_oe, err
    );

    modport slave (
        input  throttle, roll, pitch, yaw, arm, cmd_valid, pwm_busy,
        output cmd_ready, speed_out, speed_oe, err
    );
endinterface

// File: rtl/motor_mix_dispatch_speed_clamp.sv
// Saturates a 19-bit signed motor sum into the legal 16-bit PWM speed range.
module speed_clamp
    import quad_pkg::*;
#(
    parameter int MIN_SPEED = QUAD_MIN_SPEED,
    parameter int MAX_SPEED = QUAD_MAX_SPEED
) (
    input  sum19_t      i_sum,
    output logic [15:0] o_speed
);
    localparam sum19_t LO = sum19_t'(MIN_SPEED);
    localparam sum19_t HI = sum19_t'(MAX_SPEED);

    always_comb begin
        if (i_sum < LO)
            o_speed = 16'(MIN_SPEED);
        else if (i_sum > HI)
            o_speed = 16'(MAX_SPEED);
        else
            o_speed = i_sum[15:0];
    end
endmodule

// File: rtl/motor_mix_dispatch.sv
// Mixes one throttle/roll/pitch/yaw command into four clamped X-quad speeds and
// strobes each speed into its PWM channel once that channel is not busy.
module motor_mix_dispatch
    import quad_pkg::*;
#(
    parameter int MIN_SPEED     = QUAD_MIN_SPEED,
    parameter int MAX_SPEED     = QUAD_MAX_SPEED,
    parameter int ISSUE_TIMEOUT = 1024,
    parameter int STATE_WIDTH   = 3
) (
    input logic                 clk,
    input logic                 rst,
    motor_mix_dispatch_if.slave bus
);
    localparam int TO_W = $clog2(ISSUE_TIMEOUT) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ISSUE_TIMEOUT - 1);

    typedef enum logic [STATE_WIDTH-1:0] {
        S_IDLE  = STATE_WIDTH'(ST_IDLE),
        S_MIX   = STATE_WIDTH'(ST_MIX),
        S_CLAMP = STATE_WIDTH'(ST_CLAMP),
        S_ISSUE = STATE_WIDTH'(ST_ISSUE)
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [15:0]      r_throttle;
    logic [15:0]      r_roll;
    logic [15:0]      r_pitch;
    logic [15:0]      r_yaw;
    logic             r_arm;
    sum19_t           r_sum [4];
    logic [3:0][15:0] w_clamped;
    logic [3:0][15:0] r_speed;
    logic [3:0]       r_pending;
    logic [3:0]       w_pending_left;
    logic [3:0]       w_oe;
    logic             w_timeout_hit;
    logic [TO_W-1:0]  r_timeout;
    logic             r_err;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        speed_clamp #(.MIN_SPEED(MIN_SPEED), .MAX_SPEED(MAX_SPEED)) u_clamp (
            .i_sum  (r_sum[g]),
            .o_speed(w_clamped[g])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        w_next_state   = r_state;
        w_oe           = '0;
        w_pending_left = r_pending;
        w_timeout_hit  = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.cmd_valid) w_next_state = S_MIX;
            S_MIX:   w_next_state = S_CLAMP;
            S_CLAMP: w_next_state = S_ISSUE;
            S_ISSUE: begin
                w_oe           = r_pending & ~bus.pwm_busy;
                w_pending_left = r_pending & bus.pwm_busy;
                if (w_pending_left == '0) begin
                    w_next_state = S_IDLE;
                end else if (r_timeout == TO_LAST) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_throttle <= '0;
            r_roll     <= '0;
            r_pitch    <= '0;
            r_yaw      <= '0;
            r_arm      <= 1'b0;
            for (int i = 0; i < 4; i++) r_sum[i] <= '0;
            r_speed    <= {4{16'(MIN_SPEED)}};
            r_pending  <= '0;
            r_timeout  <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_throttle <= bus.throttle;
                    r_roll     <= bus.roll;
                    r_pitch    <= bus.pitch;
                    r_yaw      <= bus.yaw;
                    r_arm      <= bus.arm;
                end
                S_MIX: for (int i = 0; i < 4; i++)
                    r_sum[i] <= mix_sum(r_throttle, r_roll, r_pitch, r_yaw, MIX_NEG[i]);
                S_CLAMP: begin
                    r_speed   <= r_arm ? w_clamped : {4{16'(MIN_SPEED)}};
                    r_pending <= 4'b1111;
                    r_timeout <= '0;
                end
                S_ISSUE: begin
                    // Lanes still busy at the deadline are abandoned without a strobe.
                    r_pending <= w_timeout_hit ? 4'b0000 : w_pending_left;
                    r_timeout <= r_timeout + TO_W'(1);
                    if (w_timeout_hit) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.cmd_ready = (r_state == S_IDLE);
    assign bus.speed_out = r_speed;
    assign bus.speed_oe  = w_oe;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_motor_mix_dispatch.sv
// Scoreboard bench: expected lane speeds are queued when a command is driven and
// popped whenever the matching speed_oe strobe is seen.
module tb_motor_mix_dispatch;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    motor_mix_dispatch_if bus();
    motor_mix_dispatch dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q [4][$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [15:0] model_lane(int t, int r, int p, int y, bit arm, int i);
        int m;
        case (i)
            0:       m = t + r + p - y;
            1:       m = t - r + p + y;
            2:       m = t - r - p - y;
            default: m = t + r - p + y;
        endcase
        if (!arm || m < 256) return 16'd256;
        if (m > 65535) return 16'hFFFF;
        return 16'(m);
    endfunction

    function automatic int pending_total();
        return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
    endfunction

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.speed_oe[i]) begin
                    if (exp_q[i].size() > 0) begin
                        logic [15:0] e;
                        e = exp_q[i].pop_front();
                        check($sformatf("lane%0d_speed", i), 64'(bus.speed_out[16*i +: 16]), 64'(e));
                    end else begin
                        check($sformatf("lane%0d_unexpected_oe", i), 64'(bus.speed_oe[i]), 64'd0);
                    end
                end
            end
        end
    end

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, 64'(bus.cmd_ready), 64'd1);
    endtask

    task automatic send(input int t, input int r, input int p, input int y,
                        input bit arm, input logic [3:0] mask);
        @(negedge clk);
        wait_ready("send");
        bus.throttle  = 16'(t);
        bus.roll      = 16'(r);
        bus.pitch     = 16'(p);
        bus.yaw       = 16'(y);
        bus.arm       = arm;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++)
            if (mask[i]) exp_q[i].push_back(model_lane(t, r, p, y, arm, i));
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        wait_ready(tag);
        check({tag, "_drained"}, 64'(pending_total()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.throttle = '0; bus.roll = '0; bus.pitch = '0; bus.yaw = '0;
        bus.arm = 1'b0; bus.cmd_valid = 1'b0; bus.pwm_busy = 4'b0000;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_speed", bus.speed_out, {4{16'd256}});
        check("rst_oe", 64'(bus.speed_oe), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        rst = 1'b0;

        // Cycle-exact latency of a plain command.
        send(10000, 0, 0, 0, 1, 4'hF);
        @(negedge clk); check("basic_mix_oe", 64'(bus.speed_oe), 64'd0);
        check("basic_mix_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk); check("basic_clamp_oe", 64'(bus.speed_oe), 64'd0);
        @(negedge clk); check("basic_issue_oe", 64'(bus.speed_oe), 64'hF);
        @(negedge clk); check("basic_idle_oe", 64'(bus.speed_oe), 64'd0);
        check("basic_idle_ready", 64'(bus.cmd_ready), 64'd1);

        send(30000, 1000, 500, 200, 1, 4'hF);  finish_cmd("mixed");
        send(65000, 2000, 0, 0, 1, 4'hF);      finish_cmd("clamp_hi");
        send(300, -1000, 0, 0, 1, 4'hF);       finish_cmd("clamp_lo");
        for (int k = 0; k < 4; k++) begin
            send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                 1, 4'hF);
            finish_cmd("random");
        end

        // A command presented while busy must be dropped, not queued.
        send(20000, 0, 0, 0, 1, 4'hF);
        @(negedge clk); bus.throttle = 16'd5000; bus.cmd_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); bus.cmd_valid = 1'b0;
        finish_cmd("ignore");
        repeat (3) begin
            @(negedge clk); check("ignore_no_accept", 64'(bus.cmd_ready), 64'd1);
        end

        // Busy gating on channel 1.
        bus.pwm_busy = 4'b0010;
        send(15000, 100, -200, 300, 1, 4'hF);
        repeat (3) @(negedge clk);
        check("busy_first_oe", 64'(bus.speed_oe), 64'b1101);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("busy_hold_oe", 64'(bus.speed_oe), 64'd0);
            check("busy_hold_ready", 64'(bus.cmd_ready), 64'd0);
        end
        @(posedge clk); #1 bus.pwm_busy = 4'b0000;
        @(negedge clk); check("busy_late_oe", 64'(bus.speed_oe), 64'b0010);
        check("busy_late_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk); check("busy_done_ready", 64'(bus.cmd_ready), 64'd1);
        check("busy_drained", 64'(pending_total()), 64'd0);

        // Channel 3 stuck busy: timeout after 1024 ISSUE cycles.
        bus.pwm_busy = 4'b1000;
        send(25000, 0, 0, 0, 1, 4'b0111);
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'd1027);
        check("timeout_err", 64'(bus.err), 64'd1);
        check("timeout_drained", 64'(pending_total()), 64'd0);
        bus.pwm_busy = 4'b0000;

        send(40000, 0, 0, 0, 0, 4'hF);  finish_cmd("disarm");
        check("err_sticky", 64'(bus.err), 64'd1);

        // Asynchronous reset in the middle of ISSUE.
        bus.pwm_busy = 4'b1111;
        send(20000, 0, 0, 0, 1, 4'b0000);
        repeat (3) @(negedge clk);
        check("rst_mid_issue_ready", 64'(bus.cmd_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_async_speed", bus.speed_out, {4{16'd256}});
        check("rst_async_err", 64'(bus.err), 64'd0);
        bus.pwm_busy = 4'b0000;
        repeat (2) begin
            @(negedge clk); check("rst_hold_oe", 64'(bus.speed_oe), 64'd0);
        end
        rst = 1'b0;
        send(12345, 100, -50, 25, 1, 4'hF);  finish_cmd("post_reset");

        repeat (3) @(negedge clk);
        check("final_drained", 64'(pending_total()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/motor_mix_dispatch.md
Name: motor_mix_dispatch

Overview:
Upstream stage for four bb_pwm motor channels. Accepts one flight-control command: throttle plus signed roll/pitch/yaw corrections. Mixes the command into four X-quad motor speeds, clamps each to the legal PWM range, and delivers each speed to its PWM channel with a one-cycle speed_oe pulse. A pulse is only issued while that channel reports not busy. Sits between the attitude controller and the four bb_pwm instances.

Parameters:
MIN_SPEED, 256, lower clamp and disarmed speed; must match the PWM channel's MIN_SPEED.
MAX_SPEED, 65535, upper clamp; largest 16-bit value.
ISSUE_TIMEOUT, 1024, cycles allowed in ISSUE before abandoning pending channels.
STATE_WIDTH, 3, state register width.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
throttle  input  16  unsigned base speed
roll  input  16  signed two's-complement correction
pitch  input  16  signed two's-complement correction
yaw  input  16  signed two's-complement correction
arm  input  1  0 forces all four speeds to MIN_SPEED
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; equals (state==IDLE)
pwm_busy  input  4  busy from PWM channels 3..0
speed_out  output  64  packed speeds; motor i at bits [16i+15:16i]
speed_oe  output  4  one-cycle load strobe per channel
err  output  1  sticky issue-timeout flag

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, asynchronous and active-high.
- Reset values: state=IDLE, every speed_out lane=MIN_SPEED, speed_oe=0, err=0, pending=0, timeout counter=0. cmd_ready reads 1 during and after reset.
- Handshake: a command is accepted when cmd_valid & cmd_ready. On that edge, throttle/roll/pitch/yaw/arm are latched. cmd_ready stays low until the block returns to IDLE. cmd_valid seen while not ready is ignored; it is not queued.
- States:
  - IDLE -> MIX on accept.
  - MIX (1 cycle): compute 19-bit signed sums from the latched values, with throttle zero-extended.
    - m0 = T+R+P-Y
    - m1 = T-R+P+Y
    - m2 = T-R-P-Y
    - m3 = T+R-P+Y
  - MIX -> CLAMP.
  - CLAMP (1 cycle): each lane = MIN_SPEED if sum < MIN_SPEED, MAX_SPEED if sum > MAX_SPEED, else the sum. If the latched arm=0, all lanes = MIN_SPEED. Write speed_out, set pending=4'b1111, clear the timeout counter. CLAMP -> ISSUE.
  - ISSUE, each cycle:
    - For every i with pending[i]=1 and pwm_busy[i]=0: assert speed_oe[i] for exactly this cycle and clear pending[i] on the same edge.
    - Several lanes may strobe in the same cycle.
    - ISSUE -> IDLE when pending==0 after this cycle's clears.
    - Timeout counter increments each ISSUE cycle. When it reaches ISSUE_TIMEOUT-1 with pending≠0: set err, clear pending, go to IDLE. Lanes not yet issued receive no strobe.
- Latency: accept at edge 0; strobes for idle channels appear in the cycle after edge 2 (3rd cycle after accept). The earliest next accept is 4 cycles after the previous one.
- speed_out changes only in CLAMP, so it is stable while any speed_oe is high.
- err clears only on rst.
- Reset mid-operation: state returns to IDLE immediately, and any in-flight strobe is dropped.
- Unused state encodings -> IDLE.

Decomposition:
- Shared package (quad_pkg):
  - MIN_SPEED/MAX_SPEED defaults
  - the state encoding constants IDLE=0, MIX=1, CLAMP=2, ISSUE=3
  - mixer sign table
  - 19-bit signed sum type
- One sub-module, speed_clamp: combinational 19-bit signed to 16-bit saturator, instantiated four times.

Test Plan:
- Basic mix, T=10000, R=P=Y=0, arm=1, pwm_busy=0 -> all lanes 10000; speed_oe=4'b1111 for one cycle 3 cycles after accept; cmd_ready high the following cycle.
- Mixed command, T=30000, R=1000, P=500, Y=200 -> lanes 31300, 29700, 28300, 30700.
- Clamping:
  - T=65000, R=2000 -> 65535, 63000, 63000, 65535.
  - T=300, R=-1000 -> 256, 1300, 1300, 256.
- Busy gating, pwm_busy=4'b0010 held 5 cycles past CLAMP -> oe[0], oe[2], oe[3] strobe in the first ISSUE cycle; oe[1] strobes in the cycle busy[1] falls; cmd_ready stays low until then; no lane strobes twice.
- Timeout and disarm:
  - pwm_busy[3] stuck high -> after 1024 ISSUE cycles err=1, return to IDLE, oe[3] never strobes; err holds through later commands.
  - arm=0 with T=40000 -> all lanes 256.
- Reset, rst asserted mid-ISSUE -> outputs return to reset values asynchronously, no further strobes; after release a new command completes normally.
